// File: rtl/instruction_fetch_if.sv
// Signal bundle between the fetch unit, instruction memory and decoder.
// The master side belongs to the fetch unit; the slave side is the surrounding environment.
interface instruction_fetch_if;
  logic        pc_we;
  logic [63:0] pc_target;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic [31:0] instruction;
  logic [63:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;

  modport master (
    input  pc_we, pc_target, imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
    output imem_req_valid, imem_req_addr, instruction, inst_pc, inst_valid
  );

  modport slave (
    output pc_we, pc_target, imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
    input  imem_req_valid, imem_req_addr, instruction, inst_pc, inst_valid
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch: one outstanding memory request feeding an in-order instruction buffer.
// Define FETCH_MISALIGN_TRAP_EN to halt and flag misaligned redirects instead of truncating them.
module instruction_fetch #(
  parameter logic [63:0] RESET_PC  = 64'h0000_0000_0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic                fetch_misaligned,
`endif
  instruction_fetch_if.master bus
);
  localparam int          PTR_W = $clog2(BUF_DEPTH);
  localparam int          CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  state_t           state, state_next;
  logic [63:0]      fetch_pc, req_pc, last_pc, target_pc;
  logic [31:0]      data_mem [BUF_DEPTH];
  logic [63:0]      pc_mem [BUF_DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  logic             has_inst, accept, push, pop, in_flight, halt_next;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign target_pc = bus.pc_target;
  assign halt_next = bus.pc_we ? (bus.pc_target[1:0] != 2'b00) : fetch_misaligned;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      fetch_misaligned <= 1'b0;
    else if (bus.pc_we)
      fetch_misaligned <= (bus.pc_target[1:0] != 2'b00);
  end
`else
  assign target_pc = bus.pc_target & ~64'h3;
  assign halt_next = 1'b0;
`endif

  assign has_inst = (count != '0);
  assign accept   = (state == REQ) && bus.imem_req_ready;
  assign push     = (state == WAIT) && bus.imem_resp_valid && !bus.pc_we;
  assign pop      = has_inst && bus.inst_ready && !bus.pc_we;

  // A request accepted this cycle, or still awaiting its response, must have that response dropped.
  assign in_flight = accept ||
                     (((state == WAIT) || (state == DROP)) && !bus.imem_resp_valid);

  assign bus.imem_req_valid = (state == REQ);
  assign bus.imem_req_addr  = fetch_pc;
  assign bus.inst_valid     = has_inst;
  assign bus.instruction    = has_inst ? data_mem[head] : NOP;
  assign bus.inst_pc        = has_inst ? pc_mem[head] : last_pc;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!halt_next && (count < CNT_W'(BUF_DEPTH))) state_next = REQ;
      REQ:     if (bus.imem_req_ready) state_next = WAIT;
      WAIT:    if (bus.imem_resp_valid) state_next = IDLE;
      DROP:    if (bus.imem_resp_valid) state_next = halt_next ? IDLE : REQ;
      default: state_next = IDLE;
    endcase
    if (bus.pc_we)
      state_next = in_flight ? DROP : (halt_next ? IDLE : REQ);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      last_pc  <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      state <= state_next;
      if (has_inst)
        last_pc <= pc_mem[head];
      if (accept)
        req_pc <= fetch_pc;
      if (bus.pc_we) begin
        fetch_pc <= target_pc;
        head     <= '0;
        tail     <= '0;
        count    <= '0;
      end else begin
        if (accept)
          fetch_pc <= fetch_pc + 64'd4;
        if (push)
          tail <= tail + PTR_W'(1);
        if (pop)
          head <= head + PTR_W'(1);
        if (push && !pop)
          count <= count + CNT_W'(1);
        else if (pop && !push)
          count <= count - CNT_W'(1);
      end
    end
  end

  // Buffer storage carries no reset; entries are only read while count says they are live.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[tail] <= bus.imem_resp_data;
      pc_mem[tail]   <= req_pc;
    end
  end
endmodule
